// File: rtl/mnist_frame_loader_pkg.sv
// mnist_frame_loader_pkg: shared sizes and FSM encoding for the MNIST frame loader
package mnist_frame_loader_pkg;
  localparam int NUM_PIXELS = 784;
  localparam int PIX_IN_W = 8;
  localparam int PIX_Q_W = 4;
  localparam int ADDR_W = 10;
  localparam int NUM_CLASSES = 10;
  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_COMMIT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;
endpackage

// File: rtl/mnist_frame_loader_pixel_quantizer.sv
// mnist_frame_loader_pixel_quantizer: 8-bit grayscale to int4, round-half-up with saturation
module mnist_frame_loader_pixel_quantizer
  import mnist_frame_loader_pkg::*;
(
  input  logic [PIX_IN_W-1:0] pix,
  output logic [PIX_Q_W-1:0]  q
);
  logic [PIX_IN_W:0] s;
  assign s = {1'b0, pix} + (PIX_IN_W+1)'(8);
  // Anything past 255 after rounding would need a fifth bit, so clamp to 15.
  assign q = (s > (PIX_IN_W+1)'(255)) ? '1 : s[PIX_IN_W-1 -: PIX_Q_W];
endmodule

// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: streams one quantized 28x28 frame into the MLP pixel buffer, runs the core, returns its class
module mnist_frame_loader
  import mnist_frame_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  input  logic [PIX_IN_W-1:0] pix_data,
  input  logic                pix_last,
  output logic                pix_ready,
  output logic                buf_we,
  output logic [ADDR_W-1:0]   buf_addr,
  output logic [PIX_Q_W-1:0]  buf_wdata,
  output logic                mlp_start,
  input  logic                mlp_done,
  input  logic [3:0]          mlp_class,
  output logic                result_valid,
  output logic [3:0]          result_class,
  input  logic                result_ready,
  output logic                frame_error,
  output logic                busy
);
  state_t state, state_n;
  logic [ADDR_W-1:0] count;
  logic [PIX_Q_W-1:0] q;
  logic accept, at_end, frame_ok, frame_bad;
  mnist_frame_loader_pixel_quantizer u_quant (.pix(pix_data), .q(q));
  assign accept = pix_valid & pix_ready;
  assign at_end = count == ADDR_W'(NUM_PIXELS - 1);
  assign frame_ok = accept & pix_last & at_end;
  // Early last or missing last both mean the frame is malformed.
  assign frame_bad = accept & (pix_last ^ at_end);
  assign pix_ready = state == S_LOAD;
  assign busy = state != S_LOAD;
  assign mlp_start = state == S_START;
  assign result_valid = state == S_RESULT;
  always_ff @(posedge clk)
    if (!reset) state <= S_LOAD;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_LOAD:   state_n = frame_ok ? S_COMMIT : S_LOAD;
      S_COMMIT: state_n = S_START;
      S_START:  state_n = S_WAIT;
      S_WAIT:   state_n = mlp_done ? S_RESULT : S_WAIT;
      S_RESULT: state_n = result_ready ? S_LOAD : S_RESULT;
      default:  state_n = S_LOAD;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      count <= '0;
      buf_we <= 1'b0;
      buf_addr <= '0;
      buf_wdata <= '0;
      frame_error <= 1'b0;
      result_class <= '0;
    end else begin
      buf_we <= accept;
      frame_error <= frame_bad;
      if (accept) begin
        buf_addr <= count;
        buf_wdata <= q;
        count <= (pix_last | at_end) ? '0 : count + 1'b1;
      end
      if (state == S_WAIT && mlp_done) result_class <= mlp_class;
    end
endmodule

// File: doc/mnist_frame_loader.md
Name: mnist_frame_loader

Overview:
- Upstream feeder for the MLP inference core.
- Accepts one 28x28 image as a valid/ready stream of 8-bit grayscale pixels and quantizes each pixel to unsigned int4. Writes the results into the core's pixel buffer, then issues a one-cycle start and waits for done.
- Captures the predicted class and presents it on a valid/ready result port before accepting the next frame.

Parameters:
- NUM_PIXELS, 784, pixels per frame.
- PIX_IN_W, 8, input pixel width.
- PIX_Q_W, 4, quantized pixel width written to the buffer.
- ADDR_W, 10, buffer address width; 2**ADDR_W >= NUM_PIXELS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- pix_valid  in  1  input pixel beat valid.
- pix_data  in  PIX_IN_W  grayscale pixel, 0..255.
- pix_last  in  1  marks final pixel of frame.
- pix_ready  out  1  loader can accept a beat.
- buf_we  out  1  pixel buffer write enable.
- buf_addr  out  ADDR_W  pixel buffer write address.
- buf_wdata  out  PIX_Q_W  quantized pixel.
- mlp_start  out  1  one-cycle start pulse to the inference core.
- mlp_done  in  1  core done (level; sampled only in S_WAIT).
- mlp_class  in  4  core predicted class, valid while mlp_done=1.
- result_valid  out  1  result available.
- result_class  out  4  captured class 0..9.
- result_ready  in  1  consumer accepts result.
- frame_error  out  1  one-cycle pulse: malformed frame dropped.
- busy  out  1  high in any state except S_LOAD.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=S_LOAD, pixel count=0.
  - All outputs 0 except pix_ready=1 after reset releases.
  - Reset is honoured in every state; no start pulse is issued once reset is applied mid-operation.
- Beat acceptance: a beat is accepted on a rising edge with pix_valid=1 and pix_ready=1. pix_ready=1 only in S_LOAD.
- Quantization: q = min(15, (pix_data + 8) >> 4), computed 9 bits wide. Examples: 0->0, 7->0, 8->1, 247->15, 255->15.
- Buffer write (registered): in the cycle after an accepted beat, buf_we=1, buf_addr=count at acceptance, buf_wdata=q. Otherwise buf_we=0; buf_addr and buf_wdata hold their values.
- Frame framing:
  - Frame completes when pix_last=1 on the beat with count=NUM_PIXELS-1.
  - pix_last=1 with count<NUM_PIXELS-1: frame_error pulses next cycle, count returns to 0, state stays S_LOAD.
  - Beat at count=NUM_PIXELS-1 with pix_last=0: same error handling.
  - A dropped frame issues no start pulse. Buffer contents after a dropped frame are don't-care.
- FSM:
  - S_LOAD: on frame completion go to S_COMMIT.
  - S_COMMIT (1 cycle): final buffer write is on the port. Go to S_START.
  - S_START (1 cycle): mlp_start=1. Go to S_WAIT.
  - S_WAIT: when mlp_done=1, latch mlp_class into result_class and go to S_RESULT. mlp_done seen outside S_WAIT is ignored.
  - S_RESULT: result_valid=1 and result_class stable until result_ready=1. On the handshake cycle go to S_LOAD with count=0 and result_valid=0.
- Latency: final pixel accepted at edge T -> buf_we high in cycle T+1 -> mlp_start high in cycle T+2. Result appears at the edge where mlp_done is first sampled high in S_WAIT.
- Backpressure: pix_ready=0 throughout S_COMMIT..S_RESULT. Upstream must hold its beat while pix_ready=0.
- Counter: ADDR_W bits wide; never exceeds NUM_PIXELS-1 and never wraps.

Decomposition:
- Shared package holds:
  - constants NUM_PIXELS, PIX_IN_W, PIX_Q_W, ADDR_W, NUM_CLASSES=10;
  - the state encoding localparams S_LOAD, S_COMMIT, S_START, S_WAIT, S_RESULT (3-bit).
- Sub-module pixel_quantizer is natural: combinational 8->4 round-and-saturate, reusable for any later input path.

Test Plan:
- Reset mid-S_WAIT (reset=0 for 1 cycle) -> state S_LOAD, pix_ready=1, result_valid=0, mlp_start=0, busy=0.
- Quantizer sweep: feed pixels 0,7,8,23,24,247,255 at addrs 0..6 -> buf_wdata 0,0,1,1,2,15,15 one cycle after each accept, buf_addr 0..6.
- Full frame of 784 beats with pix_last on beat 783:
  - buf_we asserted 784 times, addrs 0..783;
  - mlp_start exactly one cycle high, two cycles after the last accept;
  - pix_ready=0 from the cycle after the last accept.
- Model core asserts mlp_done=1, mlp_class=7 twenty cycles after start, result_ready held 0 for 5 cycles -> result_valid=1 and result_class=7 stable for all 5 cycles. When result_ready=1, pix_ready returns to 1 next cycle.
- pix_last on beat 100 -> frame_error pulse next cycle, no mlp_start, next beat written at addr 0.
- 784 beats without pix_last -> frame_error pulse and no mlp_start; a following correct frame completes normally.
